matrix_lru_bank: RTL and testbench

//  Multi-set, parametrised matrix-LRU replacement tracker for set-associative caches.

---
 rtl/matrix_lru_pkg.sv | 37 +++
 rtl/matrix_lru_bank_if.sv | 53 +++++
 rtl/lru_victim_sel.sv | 36 +++
 rtl/matrix_lru_bank.sv | 145 ++++++++++++++
 tb/tb_matrix_lru_bank.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_lru_pkg.sv
// Shared types and row-update helpers for the matrix-LRU bank.
// Rows are handled at the maximum width (16 ways), and callers truncate them to WAYS.
package matrix_lru_pkg;

    localparam int unsigned MAX_WAYS  = 16;
    localparam int unsigned MAX_WAY_W = 4;

    typedef logic [MAX_WAYS-1:0]  row_t;
    typedef logic [MAX_WAY_W-1:0] widx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } lru_state_e;

    // Init row r: way r is more recent than every lower-index way.
    function automatic row_t f_lru_init(input widx_t r);
        return (row_t'(1) << r) - row_t'(1);
    endfunction

    // Promote way w to MRU, as seen by row r.
    function automatic row_t f_promote(input row_t row, input widx_t r, input widx_t w);
        if (r == w) begin
            return ~(row_t'(1) << w);
        end
        return row & ~(row_t'(1) << w);
    endfunction

    // Demote way w to LRU, as seen by row r.
    function automatic row_t f_demote(input row_t row, input widx_t r, input widx_t w);
        if (r == w) begin
            return '0;
        end
        return row | (row_t'(1) << w);
    endfunction

endpackage

// File: rtl/matrix_lru_bank_if.sv
// Request/response bundle for matrix_lru_bank.
// LRU_WAY_LOCK_EN adds the way lock mask and the all-locked flag.
interface matrix_lru_bank_if #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned WAYS     = 8
);
    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);

    logic             i_upd_vld;
    logic [SET_W-1:0] i_upd_set;
    logic [WAY_W-1:0] i_upd_way;
    logic             i_inv_vld;
    logic [SET_W-1:0] i_inv_set;
    logic [WAY_W-1:0] i_inv_way;
    logic             i_qry_vld;
    logic [SET_W-1:0] i_qry_set;
    logic             o_vic_vld;
    logic [WAY_W-1:0] o_vic_way;
    logic             i_flush;
    logic             o_busy;
`ifdef LRU_WAY_LOCK_EN
    logic [WAYS-1:0]  i_lock_mask;
    logic             o_vic_all_locked;

    modport master (
        output i_upd_vld, i_upd_set, i_upd_way,
        output i_inv_vld, i_inv_set, i_inv_way,
        output i_qry_vld, i_qry_set, i_flush, i_lock_mask,
        input  o_vic_vld, o_vic_way, o_busy, o_vic_all_locked
    );
    modport slave (
        input  i_upd_vld, i_upd_set, i_upd_way,
        input  i_inv_vld, i_inv_set, i_inv_way,
        input  i_qry_vld, i_qry_set, i_flush, i_lock_mask,
        output o_vic_vld, o_vic_way, o_busy, o_vic_all_locked
    );
`else
    modport master (
        output i_upd_vld, i_upd_set, i_upd_way,
        output i_inv_vld, i_inv_set, i_inv_way,
        output i_qry_vld, i_qry_set, i_flush,
        input  o_vic_vld, o_vic_way, o_busy
    );
    modport slave (
        input  i_upd_vld, i_upd_set, i_upd_way,
        input  i_inv_vld, i_inv_set, i_inv_way,
        input  i_qry_vld, i_qry_set, i_flush,
        output o_vic_vld, o_vic_way, o_busy
    );
`endif

endinterface

// File: rtl/lru_victim_sel.sv
// Finds the lowest-index way whose age-matrix row is all zero.
// With LRU_WAY_LOCK_EN, locked ways are skipped and masked out of every row.
module lru_victim_sel #(
    parameter  int unsigned WAYS  = 8,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WAYS-1:0] i_mat,
`ifdef LRU_WAY_LOCK_EN
    input  logic [WAYS-1:0]           i_lock_mask,
    output logic                      o_all_locked,
`endif
    output logic [WAY_W-1:0]          o_way
);

    logic w_found;

    always_comb begin
        o_way   = '0;
        w_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
`ifdef LRU_WAY_LOCK_EN
            if (!w_found && !i_lock_mask[w] && ((i_mat[w] & ~i_lock_mask) == '0)) begin
`else
            if (!w_found && (i_mat[w] == '0)) begin
`endif
                o_way   = WAY_W'(w);
                w_found = 1'b1;
            end
        end
    end

`ifdef LRU_WAY_LOCK_EN
    assign o_all_locked = &i_lock_mask;
`endif

endmodule

// File: rtl/matrix_lru_bank.sv
// Multi-set matrix-LRU replacement tracker with a registered victim query and a sequenced flush.
// Optional LRU_WAY_LOCK_EN: a global way lock mask excludes ways from victim selection.
module matrix_lru_bank
    import matrix_lru_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned WAYS     = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    matrix_lru_bank_if.slave  bus
);

    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAYS-1:0][WAYS-1:0] r_mat     [NUM_SETS];
    logic [WAYS-1:0][WAYS-1:0] w_mat_nxt [NUM_SETS];
    logic [WAYS-1:0][WAYS-1:0] w_qry_mat;

    lru_state_e       r_state;
    logic [SET_W-1:0] r_flush_idx;
    logic             r_busy;
    logic             r_vic_vld;
    logic [WAY_W-1:0] r_vic_way;
    logic [WAY_W-1:0] w_sel_way;
    logic             w_idle;
    logic             w_upd_go;
    logic             w_inv_go;
    logic             w_qry_go;

    assign w_idle   = (r_state == IDLE);
    assign w_upd_go = bus.i_upd_vld & w_idle;
    assign w_inv_go = bus.i_inv_vld & w_idle;
    // A query arriving with the flush pulse is dropped so no result appears while busy.
    assign w_qry_go = bus.i_qry_vld & w_idle & ~bus.i_flush;

    // Next matrix: promote first, then demote, so a same-way collision leaves the way LRU.
    always_comb begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
            for (int unsigned r = 0; r < WAYS; r++) begin
                w_mat_nxt[s][r] = r_mat[s][r];
                if (w_upd_go && (bus.i_upd_set == SET_W'(s))) begin
                    w_mat_nxt[s][r] = WAYS'(f_promote(row_t'(w_mat_nxt[s][r]), 4'(r), 4'(bus.i_upd_way)));
                end
                if (w_inv_go && (bus.i_inv_set == SET_W'(s))) begin
                    w_mat_nxt[s][r] = WAYS'(f_demote(row_t'(w_mat_nxt[s][r]), 4'(r), 4'(bus.i_inv_way)));
                end
                if ((r_state == FLUSH) && (r_flush_idx == SET_W'(s))) begin
                    w_mat_nxt[s][r] = WAYS'(f_lru_init(4'(r)));
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned r = 0; r < WAYS; r++) begin
                    r_mat[s][r] <= WAYS'(f_lru_init(4'(r)));
                end
            end
        end else begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                r_mat[s] <= w_mat_nxt[s];
            end
        end
    end

    // Flush sequencer: one set per cycle, busy for exactly NUM_SETS cycles.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_flush_idx <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_flush) begin
                        r_state     <= FLUSH;
                        r_flush_idx <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                FLUSH: begin
                    r_flush_idx <= r_flush_idx + SET_W'(1);
                    if (r_flush_idx == SET_W'(NUM_SETS - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_qry_mat = r_mat[bus.i_qry_set];

`ifdef LRU_WAY_LOCK_EN
    logic w_all_locked;
    logic r_vic_all_locked;

    lru_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .i_mat        (w_qry_mat),
        .i_lock_mask  (bus.i_lock_mask),
        .o_all_locked (w_all_locked),
        .o_way        (w_sel_way)
    );
`else
    lru_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .i_mat (w_qry_mat),
        .o_way (w_sel_way)
    );
`endif

    // Victim result register; the way holds until the next accepted query.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vic_vld        <= 1'b0;
            r_vic_way        <= '0;
`ifdef LRU_WAY_LOCK_EN
            r_vic_all_locked <= 1'b0;
`endif
        end else begin
            r_vic_vld <= w_qry_go;
            if (w_qry_go) begin
                r_vic_way        <= w_sel_way;
`ifdef LRU_WAY_LOCK_EN
                r_vic_all_locked <= w_all_locked;
`endif
            end
        end
    end

    assign bus.o_vic_vld = r_vic_vld;
    assign bus.o_vic_way = r_vic_way;
    assign bus.o_busy    = r_busy;
`ifdef LRU_WAY_LOCK_EN
    assign bus.o_vic_all_locked = r_vic_all_locked;
`endif

endmodule

// File: tb/tb_matrix_lru_bank.sv
// Scoreboard bench for matrix_lru_bank (NUM_SETS=16, WAYS=8); the lock cases run when LRU_WAY_LOCK_EN is defined.
module tb_matrix_lru_bank;

    localparam int unsigned NUM_SETS = 16;
    localparam int unsigned WAYS     = 8;
    localparam int unsigned SET_W    = 4;
    localparam int unsigned WAY_W    = 3;

    typedef struct packed {
        logic [WAY_W-1:0] way;
        logic             all_locked;
    } exp_t;

    logic i_clk;
    logic i_rst;

    matrix_lru_bank_if #(.NUM_SETS(NUM_SETS), .WAYS(WAYS)) bus ();

    matrix_lru_bank #(.NUM_SETS(NUM_SETS), .WAYS(WAYS)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    exp_t             exp_q[$];
    int               checks    = 0;
    int               failures  = 0;
    logic [WAY_W-1:0] last_way  = '0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clr();
        bus.i_upd_vld = 1'b0;
        bus.i_upd_set = '0;
        bus.i_upd_way = '0;
        bus.i_inv_vld = 1'b0;
        bus.i_inv_set = '0;
        bus.i_inv_way = '0;
        bus.i_qry_vld = 1'b0;
        bus.i_qry_set = '0;
        bus.i_flush   = 1'b0;
`ifdef LRU_WAY_LOCK_EN
        bus.i_lock_mask = '0;
`endif
    endtask

    task automatic push_exp(input logic [WAY_W-1:0] way, input logic locked);
        exp_t e;
        e.way        = way;
        e.all_locked = locked;
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus; a query pushes its hand-computed victim.
    task automatic cyc(input logic uv, input logic [SET_W-1:0] us, input logic [WAY_W-1:0] uw,
                       input logic iv, input logic [SET_W-1:0] is, input logic [WAY_W-1:0] iw,
                       input logic qv, input logic [SET_W-1:0] qs, input logic [WAY_W-1:0] ew);
        @(negedge i_clk);
        clr();
        bus.i_upd_vld = uv;
        bus.i_upd_set = us;
        bus.i_upd_way = uw;
        bus.i_inv_vld = iv;
        bus.i_inv_set = is;
        bus.i_inv_way = iw;
        bus.i_qry_vld = qv;
        bus.i_qry_set = qs;
        if (qv) push_exp(ew, 1'b0);
    endtask

    task automatic upd(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w);
        cyc(1'b1, s, w, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic inv(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w);
        cyc(1'b0, '0, '0, 1'b1, s, w, 1'b0, '0, '0);
    endtask

    task automatic qry(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] ew);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, s, ew);
    endtask

    task automatic idle();
        @(negedge i_clk);
        clr();
    endtask

    // Monitor: pops on every valid result, otherwise checks the victim way is held.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (bus.o_vic_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vic_vld", 32'(bus.o_vic_vld), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("vic_way", 32'(bus.o_vic_way), 32'(e.way));
`ifdef LRU_WAY_LOCK_EN
                chk("vic_all_locked", 32'(bus.o_vic_all_locked), 32'(e.all_locked));
`endif
                last_way = e.way;
            end
        end else begin
            chk("vic_way_hold", 32'(bus.o_vic_way), 32'(last_way));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b0;
        clr();
        repeat (2) @(negedge i_clk);
        chk("reset_busy", 32'(bus.o_busy), 32'(0));
        chk("reset_vic_vld", 32'(bus.o_vic_vld), 32'(0));
        chk("reset_vic_way", 32'(bus.o_vic_way), 32'(0));
        i_rst = 1'b1;

        // Fresh set: way 0 is LRU
        qry(4'd3, 3'd0);

        // Promote 0,1,2 in set 3: way 3 becomes LRU; neighbour set untouched
        upd(4'd3, 3'd0);
        upd(4'd3, 3'd1);
        upd(4'd3, 3'd2);
        qry(4'd3, 3'd3);
        qry(4'd4, 3'd0);

        // Invalidate makes a way LRU; same-way update+invalidate ends LRU
        upd(4'd5, 3'd0);
        inv(4'd5, 3'd6);
        qry(4'd5, 3'd6);
        cyc(1'b1, 4'd5, 3'd2, 1'b1, 4'd5, 3'd2, 1'b0, '0, '0);
        qry(4'd5, 3'd2);

        // Update and invalidate in different sets in the same cycle
        cyc(1'b1, 4'd6, 3'd0, 1'b1, 4'd7, 3'd5, 1'b0, '0, '0);
        qry(4'd6, 3'd1);
        qry(4'd7, 3'd5);

        // Same set, different ways: both applied
        cyc(1'b1, 4'd8, 3'd3, 1'b1, 4'd8, 3'd5, 1'b0, '0, '0);
        qry(4'd8, 3'd5);
        upd(4'd8, 3'd5);
        qry(4'd8, 3'd0);

        // Read-old: a query sees the state before a same-cycle update
        cyc(1'b1, 4'd1, 3'd0, 1'b0, '0, '0, 1'b1, 4'd1, 3'd0);
        qry(4'd1, 3'd1);
        idle();
        idle();

        // Dirty every set, then flush
        for (int s = 0; s < NUM_SETS; s++) upd(SET_W'(s), 3'd0);
        @(negedge i_clk);
        clr();
        bus.i_flush = 1'b1;
        for (int i = 0; i < NUM_SETS; i++) begin
            @(negedge i_clk);
            clr();
            chk("flush_busy", 32'(bus.o_busy), 32'(1));
            chk("flush_vic_vld", 32'(bus.o_vic_vld), 32'(0));
            bus.i_qry_vld = 1'b1;
            bus.i_qry_set = SET_W'(i);
            bus.i_upd_vld = 1'b1;
            bus.i_upd_set = SET_W'(i);
            bus.i_upd_way = 3'd0;
            if (i == 3) bus.i_flush = 1'b1;
        end
        @(negedge i_clk);
        clr();
        chk("flush_done_busy", 32'(bus.o_busy), 32'(0));
        idle();
        chk("flush_no_restart", 32'(bus.o_busy), 32'(0));
        for (int s = 0; s < NUM_SETS; s++) qry(SET_W'(s), 3'd0);

        // Reset in the middle of a flush
        upd(4'd12, 3'd0);
        @(negedge i_clk);
        clr();
        bus.i_flush = 1'b1;
        repeat (5) idle();
        chk("midflush_busy_before", 32'(bus.o_busy), 32'(1));
        i_rst    = 1'b0;
        last_way = '0;
        #1;
        chk("midflush_rst_busy", 32'(bus.o_busy), 32'(0));
        @(negedge i_clk);
        i_rst = 1'b1;
        chk("after_rst_busy", 32'(bus.o_busy), 32'(0));
        qry(4'd12, 3'd0);
        idle();
        chk("after_rst_idle", 32'(bus.o_busy), 32'(0));

`ifdef LRU_WAY_LOCK_EN
        @(negedge i_clk);
        i_rst    = 1'b0;
        last_way = '0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        clr();
        bus.i_qry_vld   = 1'b1;
        bus.i_qry_set   = 4'd0;
        bus.i_lock_mask = 8'h03;
        push_exp(3'd2, 1'b0);
        @(negedge i_clk);
        clr();
        bus.i_qry_vld   = 1'b1;
        bus.i_qry_set   = 4'd0;
        bus.i_lock_mask = 8'hFF;
        push_exp(3'd0, 1'b1);
`endif

        repeat (3) idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
